// File: rtl/game_sequencer.sv
// Turn sequencer for a shared-board game: takes one move per turn, validates it
// against the board memory, commits accepted moves and detects end of game.
module game_sequencer #(
  parameter int NUM_CELLS   = 9,
  parameter int ADDR_W      = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int PID_W       = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic [PID_W-1:0]  first_player,
  input  logic              player_write,
  input  logic [ADDR_W-1:0] player_input,
  input  logic              cell_occupied,
  input  logic              game_is_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PID_W-1:0]  wr_player,
  output logic [PID_W-1:0]  cur_player,
  output logic [1:0]        game_state,
  output logic [ADDR_W:0]   move_count,
  output logic              move_reject,
  output logic              timeout_skip,
  output logic              board_full
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_TURN  = 2'd1,
    S_CHECK = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0]  CELLS   = (ADDR_W+1)'(NUM_CELLS);
  localparam logic [PID_W:0]   NPLAY   = (PID_W+1)'(NUM_PLAYERS);
  localparam logic [PID_W-1:0] LAST_P  = PID_W'(NUM_PLAYERS - 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   pend;
  logic [TW-1:0]       tcnt;
  logic                accept;
  logic [ADDR_W:0]     next_count;
  logic [PID_W-1:0]    next_player;

  assign game_state  = state;
  assign rd_addr     = pend;
  assign wr_addr     = pend;
  assign wr_player   = cur_player;
  assign accept      = ({1'b0, pend} < CELLS) && !cell_occupied;
  assign next_count  = move_count + 1'b1;
  assign next_player = (cur_player == LAST_P) ? '0 : cur_player + 1'b1;

  // Write/reject decide in the CHECK cycle itself; a coincident reset or win
  // drops the move so the board never sees a write that the FSM discards.
  always_comb begin
    wr_en       = 1'b0;
    move_reject = 1'b0;
    if (!reset && state == S_CHECK && !game_is_done) begin
      wr_en       = accept;
      move_reject = !accept;
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state        <= S_START;
      cur_player   <= '0;
      move_count   <= '0;
      pend         <= '0;
      tcnt         <= '0;
      timeout_skip <= 1'b0;
      board_full   <= 1'b0;
    end else begin
      timeout_skip <= 1'b0;
      case (state)
        S_START: begin
          state      <= S_TURN;
          tcnt       <= '0;
          cur_player <= ({1'b0, first_player} < NPLAY) ? first_player : '0;
        end
        S_TURN: begin
          if (game_is_done) begin
            state <= S_END;
          end else if (player_write) begin
            pend  <= player_input;
            state <= S_CHECK;
          end else if (TIMEOUT > 0) begin
            if (tcnt == TO_LAST) begin
              timeout_skip <= 1'b1;
              cur_player   <= next_player;
              tcnt         <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          tcnt <= '0;
          if (game_is_done) begin
            state <= S_END;
          end else if (accept) begin
            move_count <= next_count;
            cur_player <= next_player;
            if (next_count == CELLS) begin
              state      <= S_END;
              board_full <= 1'b1;
            end else begin
              state <= S_TURN;
            end
          end else begin
            state <= S_TURN;
          end
        end
        default: ;  // S_END holds until reset
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed vector bench for game_sequencer: default 9-cell/2-player instance
// plus a 3-player instance with a 5-cycle turn timeout.
module tb_game_sequencer;

  logic       ph1;
  logic       reset, player_write, cell_occupied, game_is_done;
  logic [1:0] first_player;
  logic [3:0] player_input;
  logic [3:0] rd_addr, wr_addr;
  logic       wr_en, move_reject, timeout_skip, board_full;
  logic [1:0] wr_player, cur_player, game_state;
  logic [4:0] move_count;

  logic       rst3;
  logic       zero3;
  logic [1:0] fp3;
  logic [3:0] pin3;
  logic [3:0] rd3, wa3;
  logic       we3, rej3, skip3, bf3;
  logic [1:0] wp3, cp3, st3;
  logic [4:0] mc3;

  int ncmp = 0;
  int nerr = 0;

  game_sequencer dut (
    .ph1(ph1), .reset(reset), .first_player(first_player),
    .player_write(player_write), .player_input(player_input),
    .cell_occupied(cell_occupied), .game_is_done(game_is_done),
    .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_player(wr_player),
    .cur_player(cur_player), .game_state(game_state), .move_count(move_count),
    .move_reject(move_reject), .timeout_skip(timeout_skip), .board_full(board_full)
  );

  game_sequencer #(.NUM_PLAYERS(3), .TIMEOUT(5)) dut3 (
    .ph1(ph1), .reset(rst3), .first_player(fp3),
    .player_write(zero3), .player_input(pin3),
    .cell_occupied(zero3), .game_is_done(zero3),
    .rd_addr(rd3), .wr_en(we3), .wr_addr(wa3), .wr_player(wp3),
    .cur_player(cp3), .game_state(st3), .move_count(mc3),
    .move_reject(rej3), .timeout_skip(skip3), .board_full(bf3)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct {
    logic       rst;
    logic [1:0] fp;
    logic       pw;
    logic [3:0] pin;
    logic       occ;
    logic       gd;
    logic [1:0] st;
    logic [1:0] cp;
    logic [4:0] mc;
    logic       we;
    logic [3:0] wa;
    logic [1:0] wp;
    logic       rej;
    logic       bf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] fp, input logic pw,
                              input logic [3:0] pin, input logic occ, input logic gd,
                              input logic [1:0] st, input logic [1:0] cp, input logic [4:0] mc,
                              input logic we, input logic [3:0] wa, input logic [1:0] wp,
                              input logic rej, input logic bf);
    vec_t v;
    v.rst = rst; v.fp = fp; v.pw = pw; v.pin = pin; v.occ = occ; v.gd = gd;
    v.st = st; v.cp = cp; v.mc = mc; v.we = we; v.wa = wa; v.wp = wp;
    v.rej = rej; v.bf = bf;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Advance one cycle, drive inputs just after the edge, settle before checking.
  task automatic tick(input logic rst, input logic [1:0] fp, input logic pw,
                      input logic [3:0] pin, input logic occ, input logic gd);
    @(posedge ph1);
    #1;
    reset = rst; first_player = fp; player_write = pw;
    player_input = pin; cell_occupied = occ; game_is_done = gd;
    #3;
  endtask

  initial begin
    reset = 1'b1; first_player = 2'd0; player_write = 1'b0; player_input = 4'd0;
    cell_occupied = 1'b0; game_is_done = 1'b0;
    rst3 = 1'b1; zero3 = 1'b0; fp3 = 2'd0; pin3 = 4'd0;

    //        rst fp pw pin occ gd | st cp mc we wa wp rej bf
    vt.push_back(mk(1, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // reset state
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // START
    vt.push_back(mk(0, 1, 1,  4, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0)); // P1 moves to 4
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  2, 1, 0, 1, 4, 1, 0, 0)); // accept, write
    vt.push_back(mk(0, 1, 1, 12, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0)); // out of range
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  2, 0, 1, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1,  9, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0)); // addr == NUM_CELLS
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  2, 0, 1, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1,  8, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0)); // occupied cell
    vt.push_back(mk(0, 1, 0,  0, 1, 0,  2, 0, 1, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1,  8, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0)); // last valid cell
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  2, 0, 1, 1, 8, 0, 0, 0));
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  1, 1, 2, 0, 0, 0, 0, 0)); // idle, no timeout
    vt.push_back(mk(0, 1, 1,  0, 0, 0,  1, 1, 2, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1,  3, 0, 0,  2, 1, 2, 1, 0, 1, 0, 0)); // write in CHECK ignored
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  1, 0, 3, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1,  5, 0, 1,  1, 0, 3, 0, 0, 0, 0, 0)); // done beats write
    vt.push_back(mk(0, 1, 1,  2, 0, 0,  3, 0, 3, 0, 0, 0, 0, 0)); // END ignores write
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  3, 0, 3, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0,  0, 0, 0,  3, 0, 3, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 3, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // invalid first player
    vt.push_back(mk(0, 3, 1,  2, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 3, 0,  0, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0)); // done beats accept
    vt.push_back(mk(0, 3, 0,  0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0,  0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1,  3, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0,  0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0)); // reset mid-CHECK
    vt.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge ph1);

    foreach (vt[i]) begin
      tick(vt[i].rst, vt[i].fp, vt[i].pw, vt[i].pin, vt[i].occ, vt[i].gd);
      chk($sformatf("v%0d.state", i), game_state, vt[i].st);
      chk($sformatf("v%0d.cur_player", i), cur_player, vt[i].cp);
      chk($sformatf("v%0d.move_count", i), move_count, vt[i].mc);
      chk($sformatf("v%0d.wr_en", i), wr_en, vt[i].we);
      chk($sformatf("v%0d.move_reject", i), move_reject, vt[i].rej);
      chk($sformatf("v%0d.board_full", i), board_full, vt[i].bf);
      chk($sformatf("v%0d.timeout_skip", i), timeout_skip, 0);
      if (vt[i].we) begin
        chk($sformatf("v%0d.wr_addr", i), wr_addr, vt[i].wa);
        chk($sformatf("v%0d.wr_player", i), wr_player, vt[i].wp);
      end
    end

    // Fill the whole board: nine accepted moves end the game.
    for (int m = 0; m < 9; m++) begin
      tick(0, 0, 1, 4'(m), 0, 0);
      chk($sformatf("full%0d.turn", m), game_state, 1);
      chk($sformatf("full%0d.cur_player", m), cur_player, m % 2);
      chk($sformatf("full%0d.move_count", m), move_count, m);
      tick(0, 0, 0, 0, 0, 0);
      chk($sformatf("full%0d.check", m), game_state, 2);
      chk($sformatf("full%0d.wr_en", m), wr_en, 1);
      chk($sformatf("full%0d.wr_addr", m), wr_addr, m);
      chk($sformatf("full%0d.wr_player", m), wr_player, m % 2);
    end
    tick(0, 0, 0, 0, 0, 0);
    chk("full.end_state", game_state, 3);
    chk("full.move_count", move_count, 9);
    chk("full.board_full", board_full, 1);
    chk("full.cur_player", cur_player, 1);
    tick(0, 0, 1, 0, 0, 0);
    chk("full.hold_state", game_state, 3);
    chk("full.hold_wr_en", wr_en, 0);
    chk("full.hold_count", move_count, 9);

    // Timeout instance: three players, no moves, a skip every 5 TURN cycles.
    @(posedge ph1);
    #1 rst3 = 1'b0;
    #3 chk("to.start", st3, 0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge ph1);
      #4;
      chk($sformatf("to%0d.state", k), st3, 1);
      chk($sformatf("to%0d.skip", k), skip3, (k >= 6 && k % 5 == 1) ? 1 : 0);
      chk($sformatf("to%0d.cur_player", k), cp3, ((k - 1) / 5) % 3);
      chk($sformatf("to%0d.move_count", k), mc3, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
